// File: rtl/sort16_feeder_pkg.sv
// Shared constants and state encoding for the 16-byte sort feeder.
package sort16_feeder_pkg;

    localparam int unsigned NBYTES = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = NBYTES * BYTE_W;
    localparam int unsigned CNT_W  = $clog2(NBYTES);

    typedef enum logic [1:0] {
        StFill  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } state_e;

endpackage

// File: rtl/sort16_feeder_ser.sv
// 128-bit to byte serializer: captures the sorted block on load and presents
// byte idx (MSB byte first) while active.
module sort16_feeder_ser
    import sort16_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              active,
    input  logic [CNT_W-1:0]  idx,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              last
);

    logic [DATA_W-1:0] res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (load) begin
            res_q <= data;
        end
    end

    always_comb begin
        out_valid = active;
        out_data  = '0;
        if (active) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (idx == CNT_W'(i)) begin
                    out_data = res_q[(NBYTES - 1 - i) * BYTE_W +: BYTE_W];
                end
            end
        end
        last = active && out_ready && (idx == CNT_W'(NBYTES - 1));
    end

endmodule

// File: rtl/sort16_feeder.sv
// Collects 16 bytes, hands them to an external sorter and streams the sorted
// result back out. Optional WAIT timeout enabled by SORT16_FEEDER_TIMEOUT_EN.
module sort16_feeder
    import sort16_feeder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sort_start,
    output logic [DATA_W-1:0] sort_data,
    input  logic              sort_done,
    input  logic [DATA_W-1:0] sort_result,
    output logic              busy
`ifdef SORT16_FEEDER_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sort_data_q, sort_data_d;
    logic              load;
    logic              drain_last;

`ifdef SORT16_FEEDER_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1);
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            cnt_q       <= '0;
            sort_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sort_data_q <= sort_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sort_data_d = sort_data_q;
        load        = 1'b0;
`ifdef SORT16_FEEDER_TIMEOUT_EN
        wait_cnt_d  = '0;
        timeout_d   = 1'b0;
`endif
        unique case (state_q)
            StFill: begin
                if (in_valid) begin
                    for (int unsigned i = 0; i < NBYTES; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            sort_data_d[(NBYTES - 1 - i) * BYTE_W +: BYTE_W] = in_data;
                        end
                    end
                    if (cnt_q == CNT_W'(NBYTES - 1)) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                // A sort_done on the limit cycle takes priority over the timeout.
                if (sort_done) begin
                    load    = 1'b1;
                    state_d = StDrain;
                end
`ifdef SORT16_FEEDER_TIMEOUT_EN
                else if (wait_cnt_q == WaitW'(TIMEOUT_CYC - 1)) begin
                    state_d     = StFill;
                    sort_data_d = '0;
                    timeout_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            StDrain: begin
                if (out_ready) begin
                    if (drain_last) begin
                        state_d = StFill;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    sort16_feeder_ser u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data      (sort_result),
        .active    (state_q == StDrain),
        .idx       (cnt_q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .last      (drain_last)
    );

    assign in_ready   = (state_q == StFill);
    assign sort_start = (state_q == StStart);
    assign busy       = (state_q != StFill);
    assign sort_data  = sort_data_q;

endmodule

// File: tb/tb_sort16_feeder.sv
// Randomized self-checking bench for sort16_feeder with a behavioural sorter;
// the timeout scenario runs when SORT16_FEEDER_TIMEOUT_EN is defined.
module tb_sort16_feeder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_ready;
    logic         sort_start;
    logic [127:0] sort_data;
    logic         sort_done;
    logic [127:0] sort_result;
    logic         busy;
`ifdef SORT16_FEEDER_TIMEOUT_EN
    logic         timeout_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sort16_feeder #(
        .TIMEOUT_CYC (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .sort_start  (sort_start),
        .sort_data   (sort_data),
        .sort_done   (sort_done),
        .sort_result (sort_result),
        .busy        (busy)
`ifdef SORT16_FEEDER_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference sorter: largest byte ends up in the MSB byte.
    function automatic logic [127:0] sort_desc(input logic [127:0] blk);
        logic [7:0]   b[16];
        logic [7:0]   t;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = blk[127-8*i -: 8];
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 15 - i; j++) begin
                if (b[j] < b[j+1]) begin
                    t = b[j]; b[j] = b[j+1]; b[j+1] = t;
                end
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Feeds blk from FILL; returns sampled in the START cycle.
    task automatic fill_block(input logic [127:0] blk, input int gap_pct);
        int   k;
        int   guard;
        logic v;
        k = 0;
        guard = 0;
        while (k < 16 && guard < 400) begin
            v = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            in_data  = v ? blk[127-8*k -: 8] : 8'($urandom);
            total++;
            if (in_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL fill_ready k=%0d: in_ready=%b busy=%b, required 1/0", k, in_ready, busy);
            end
            step();
            if (v) k++;
            guard++;
        end
        in_valid = 1'b0;
        if (k < 16) begin
            total++; bad++;
            $display("FAIL fill_budget: accepted %0d bytes, required 16", k);
        end
        total++;
        if (sort_start !== 1'b1 || sort_data !== blk) begin
            bad++;
            $display("FAIL start: sort_start=%b sort_data=%h, required 1 %h", sort_start, sort_data, blk);
        end
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_flags: in_ready=%b busy=%b out_valid=%b, required 0/1/0",
                     in_ready, busy, out_valid);
        end
    endtask

    // From START: waits lat WAIT cycles, answers with the sorted block, drains.
    task automatic drain_block(input logic [127:0] blk, input int lat, input int gap_pct,
                               input int stall_at, input bit spurious);
        logic [127:0] exp;
        int           m;
        int           guard;
        int           stall;
        logic         r;
        exp = sort_desc(blk);
        step();
        total++;
        if (sort_start !== 1'b0) begin
            bad++;
            $display("FAIL start_pulse: sort_start=%b in WAIT, required 0", sort_start);
        end
        for (int i = 0; i < lat; i++) begin
            in_valid = 1'($urandom_range(1));
            in_data  = 8'($urandom);
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1 || sort_data !== blk) begin
                bad++;
                $display("FAIL wait_state: in_ready=%b out_valid=%b busy=%b sort_data=%h, required 0/0/1 %h",
                         in_ready, out_valid, busy, sort_data, blk);
            end
            step();
        end
        sort_done   = 1'b1;
        sort_result = exp;
        total++;
        if (sort_data !== blk) begin
            bad++;
            $display("FAIL wait_hold: sort_data=%h, required %h", sort_data, blk);
        end
        step();
        sort_done   = 1'b0;
        sort_result = rand_blk();
        in_valid    = 1'b0;
        m = 0;
        guard = 0;
        stall = 0;
        while (m < 16 && guard < 400) begin
            if (stall_at == m && stall < 5) begin
                r = 1'b0;
                stall++;
            end else begin
                r = ($urandom_range(99) >= gap_pct);
            end
            out_ready = r;
            if (spurious && m == 3) begin
                sort_done   = 1'b1;
                sort_result = rand_blk();
            end
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[127-8*m -: 8] || busy !== 1'b1 ||
                in_ready !== 1'b0) begin
                bad++;
                $display("FAIL drain_byte m=%0d: valid=%b data=%h busy=%b in_ready=%b, required 1 %h 1 0",
                         m, out_valid, out_data, busy, in_ready, exp[127-8*m -: 8]);
            end
`ifdef SORT16_FEEDER_TIMEOUT_EN
            total++;
            if (timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL drain_no_timeout m=%0d: timeout_err=%b, required 0", m, timeout_err);
            end
`endif
            step();
            sort_done = 1'b0;
            if (r) m++;
            guard++;
        end
        out_ready = 1'b0;
        if (m < 16) begin
            total++; bad++;
            $display("FAIL drain_budget: emitted %0d bytes, required 16", m);
        end
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL after_drain: busy=%b in_ready=%b out_valid=%b, required 0/1/0",
                     busy, in_ready, out_valid);
        end
    endtask

    task automatic check_idle(input string tag);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sort_start !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: in_ready=%b out_valid=%b sort_start=%b busy=%b, required 1/0/0/0",
                     tag, in_ready, out_valid, sort_start, busy);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_idle(tag);
        total++;
        if (out_data !== 8'h00 || sort_data !== 128'h0) begin
            bad++;
            $display("FAIL %s_data: out_data=%h sort_data=%h, required 0 0", tag, out_data, sort_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_async");
        step();
        step();
        check_reset_vals("reset_held");
        rst_n = 1'b1;
        step();
        check_idle("reset_release");
    endtask

    task automatic test_ascending();
        logic [127:0] blk;
        for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'(i);
        fill_block(blk, 0);
        drain_block(blk, 2, 0, -1, 1'b0);
    endtask

    task automatic test_equal();
        logic [127:0] blk;
        blk = {16{8'hA5}};
        fill_block(blk, 0);
        drain_block(blk, 0, 0, -1, 1'b0);
    endtask

    task automatic test_stall();
        logic [127:0] blk;
        blk = rand_blk();
        fill_block(blk, 0);
        drain_block(blk, 3, 0, 7, 1'b0);
    endtask

    task automatic test_spurious();
        logic [127:0] blk;
        for (int i = 0; i < 2; i++) begin
            sort_done   = 1'b1;
            sort_result = rand_blk();
            step();
            sort_done = 1'b0;
            check_idle("spurious_fill");
        end
        blk = rand_blk();
        fill_block(blk, 20);
        drain_block(blk, 4, 0, -1, 1'b1);
    endtask

    task automatic test_wait_reset();
        logic [127:0] blk;
        blk = rand_blk();
        fill_block(blk, 0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_reset_vals("wait_reset");
        step();
        rst_n = 1'b1;
        step();
        sort_done   = 1'b1;
        sort_result = rand_blk();
        step();
        sort_done = 1'b0;
        check_idle("done_after_reset");
        step();
        check_idle("done_after_reset2");
        blk = rand_blk();
        fill_block(blk, 0);
        drain_block(blk, 1, 0, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [127:0] blk;
        for (int n = 0; n < 5; n++) begin
            blk = rand_blk();
            if (n == 4) blk[63:0] = blk[127:64];
            fill_block(blk, 30);
            drain_block(blk, int'($urandom_range(5)), 30, -1, 1'($urandom_range(1)));
        end
    endtask

`ifdef SORT16_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        logic [127:0] blk;
        blk = rand_blk();
        fill_block(blk, 0);
        step();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (timeout_err !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL timeout_wait c=%0d: timeout_err=%b busy=%b in_ready=%b, required 0/1/0",
                         i + 1, timeout_err, busy, in_ready);
            end
            step();
        end
        total++;
        if (timeout_err !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || sort_data !== 128'h0) begin
            bad++;
            $display("FAIL timeout_fire: timeout_err=%b in_ready=%b busy=%b sort_data=%h, required 1/1/0 0",
                     timeout_err, in_ready, busy, sort_data);
        end
        step();
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: timeout_err=%b, required 0", timeout_err);
        end
        blk = rand_blk();
        fill_block(blk, 0);
        drain_block(blk, 9, 0, -1, 1'b0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b0;
        sort_done   = 1'b0;
        sort_result = '0;
        test_reset();
        test_ascending();
        test_equal();
        test_stall();
        test_spurious();
        test_wait_reset();
        test_random();
`ifdef SORT16_FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
